// File: rtl/lockin_pkg.sv
// rtl/lockin_pkg.sv - shared defaults, FSM encoding and reference-table helpers for the lock-in demodulator
//
// Contents:
//   LOCKIN_*            default parameter values for lockin_demod
//   ST_IDLE/ACCUM/DONE  2-bit FSM state encoding
//   clog2               ceiling log2 for elaboration-time widths
//   ref_sin / ref_cos   reference table entries, round(A*sin/cos(2*pi*k/M))
package lockin_pkg;

    localparam int LOCKIN_M      = 32;
    localparam int LOCKIN_CYCLES = 8;
    localparam int LOCKIN_DATA_W = 32;
    localparam int LOCKIN_REF_W  = 16;
    localparam int LOCKIN_ACC_W  = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam real TWO_PI = 6.283185307179586;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

    // First-quadrant sample, j in 0..m/4. A Taylor series keeps this free of
    // math library calls so it evaluates as a plain constant function.
    function automatic int quad_sin(input int j, input int m, input int amp);
        real x;
        real term;
        real s;
        x    = TWO_PI * $itor(j) / $itor(m);
        term = x;
        s    = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / $itor((2 * n) * (2 * n + 1));
            s    = s + term;
        end
        // Value is never negative here, so +0.5 and truncate is round-to-nearest.
        return $rtoi($itor(amp) * s + 0.5);
    endfunction

    // Full period mirrored from the first quadrant so the symmetries
    // sin[M/2-k]=sin[k] and sin[M-k]=-sin[k] hold exactly; that is what makes
    // sum(sin), sum(cos) and sum(sin*cos) vanish with no residue.
    function automatic int ref_sin(input int k, input int m, input int amp);
        int quarter;
        int half;
        quarter = m / 4;
        half    = m / 2;
        if (k <= quarter) begin
            return quad_sin(k, m, amp);
        end else if (k <= half) begin
            return quad_sin(half - k, m, amp);
        end else if (k <= half + quarter) begin
            return -quad_sin(k - half, m, amp);
        end
        return -quad_sin(m - k, m, amp);
    endfunction

    function automatic int ref_cos(input int k, input int m, input int amp);
        return ref_sin((k + m / 4) % m, m, amp);
    endfunction

endpackage

// File: rtl/lockin_ref_rom.sv
// rtl/lockin_ref_rom.sv - M-entry cos/sin reference table with registered read
//
// Ports:
//   clk      in   1               rising-edge clock
//   reset    in   1               asynchronous active-high, clears the read registers
//   idx      in   clog2(M)        phase index
//   cos_out  out  REF_W signed    cos[idx], one cycle after idx
//   sin_out  out  REF_W signed    sin[idx], one cycle after idx
module lockin_ref_rom
    import lockin_pkg::*;
#(
    parameter int M     = LOCKIN_M,
    parameter int REF_W = LOCKIN_REF_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [clog2(M)-1:0]     idx,
    output logic signed [REF_W-1:0] cos_out,
    output logic signed [REF_W-1:0] sin_out
);

    localparam int AMP = (1 << (REF_W - 1)) - 1;

    logic signed [REF_W-1:0] cos_tab [M];
    logic signed [REF_W-1:0] sin_tab [M];

    for (genvar k = 0; k < M; k++) begin : g_tab
        localparam int COS_V = ref_cos(k, M, AMP);
        localparam int SIN_V = ref_sin(k, M, AMP);
        assign cos_tab[k] = COS_V[REF_W-1:0];
        assign sin_tab[k] = SIN_V[REF_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cos_out <= '0;
            sin_out <= '0;
        end else begin
            cos_out <= cos_tab[idx];
            sin_out <= sin_tab[idx];
        end
    end

endmodule

// File: rtl/lockin_demod.sv
// rtl/lockin_demod.sv - digital lock-in: multiplies averaged frames by cos/sin and sums I/Q over CYCLES periods
//
// Ports:
//   clk             in   1              rising-edge clock
//   reset           in   1              asynchronous active-high, clears all state
//   sync_clear      in   1              drops the partial result, phase index back to 0
//   data_in_valid   in   1              one accepted sample per asserted cycle
//   data_in         in   DATA_W signed  averaged sample
//   data_out_valid  out  1              one-cycle pulse, i_out/q_out carry a new result
//   i_out           out  ACC_W signed   sum(x[k]*cos[k]) over M*CYCLES samples
//   q_out           out  ACC_W signed   sum(x[k]*sin[k]) over M*CYCLES samples
//   busy            out  1              high from first accepted sample until the result pulse
module lockin_demod
    import lockin_pkg::*;
#(
    parameter int M      = LOCKIN_M,
    parameter int CYCLES = LOCKIN_CYCLES,
    parameter int DATA_W = LOCKIN_DATA_W,
    parameter int REF_W  = LOCKIN_REF_W,
    parameter int ACC_W  = LOCKIN_ACC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sync_clear,
    input  logic                     data_in_valid,
    input  logic signed [DATA_W-1:0] data_in,
    output logic                     data_out_valid,
    output logic signed [ACC_W-1:0]  i_out,
    output logic signed [ACC_W-1:0]  q_out,
    output logic                     busy
);

    localparam int TOTAL  = M * CYCLES;
    localparam int IDX_W  = clog2(M);
    localparam int CNT_W  = clog2(TOTAL);
    localparam int PROD_W = DATA_W + REF_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);

    logic accept;

    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;

    // S1: sample, phase and end-of-block marker
    logic                     s1_valid;
    logic                     s1_last;
    logic signed [DATA_W-1:0] s1_data;
    logic [IDX_W-1:0]         s1_idx;

    // S2a: sample delayed to line up with the registered ROM read
    logic                     s2_valid;
    logic                     s2_last;
    logic signed [DATA_W-1:0] s2_data;
    logic signed [REF_W-1:0]  rom_cos;
    logic signed [REF_W-1:0]  rom_sin;

    // S2b: registered products
    logic                     p_valid;
    logic                     p_last;
    logic signed [PROD_W-1:0] prod_i;
    logic signed [PROD_W-1:0] prod_q;

    // S3: accumulators and the finished sums waiting for the pulse
    logic signed [ACC_W-1:0]  acc_i;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  sum_i;
    logic signed [ACC_W-1:0]  sum_q;
    logic signed [ACC_W-1:0]  res_i;
    logic signed [ACC_W-1:0]  res_q;

    logic [1:0] state;
    logic       in_flight;

    // A sample arriving together with sync_clear belongs to the discarded block.
    assign accept    = data_in_valid & ~sync_clear;
    assign in_flight = accept | s1_valid | s2_valid | p_valid;
    assign busy      = (state != ST_IDLE);

    assign sum_i = acc_i + {{(ACC_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};
    assign sum_q = acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

    lockin_ref_rom #(
        .M     (M),
        .REF_W (REF_W)
    ) u_ref_rom (
        .clk     (clk),
        .reset   (reset),
        .idx     (s1_idx),
        .cos_out (rom_cos),
        .sin_out (rom_sin)
    );

    // Phase/count tracking and the multiply pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_data  <= '0;
            s1_idx   <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_data  <= '0;
            p_valid  <= 1'b0;
            p_last   <= 1'b0;
            prod_i   <= '0;
            prod_q   <= '0;
        end else if (sync_clear) begin
            idx      <= '0;
            cnt      <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            p_valid  <= 1'b0;
        end else begin
            if (accept) begin
                // M is a power of two, so the index wraps M-1 -> 0 on overflow.
                idx <= idx + IDX_W'(1);
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            end
            s1_valid <= accept;
            s1_last  <= (cnt == CNT_LAST);
            s1_data  <= data_in;
            s1_idx   <= idx;

            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_data  <= s1_data;

            p_valid  <= s2_valid;
            p_last   <= s2_last;
            prod_i   <= PROD_W'(s2_data) * PROD_W'(rom_cos);
            prod_q   <= PROD_W'(s2_data) * PROD_W'(rom_sin);
        end
    end

    // Accumulation, block FSM and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_i          <= '0;
            acc_q          <= '0;
            res_i          <= '0;
            res_q          <= '0;
            i_out          <= '0;
            q_out          <= '0;
            data_out_valid <= 1'b0;
            state          <= ST_IDLE;
        end else if (sync_clear) begin
            acc_i          <= '0;
            acc_q          <= '0;
            data_out_valid <= 1'b0;
            state          <= ST_IDLE;
        end else begin
            if (p_valid) begin
                if (p_last) begin
                    // Restart from zero right away so a following block needs no idle gap.
                    acc_i <= '0;
                    acc_q <= '0;
                    res_i <= sum_i;
                    res_q <= sum_q;
                end else begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                end
            end

            data_out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (p_valid && p_last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    data_out_valid <= 1'b1;
                    i_out          <= res_i;
                    q_out          <= res_q;
                    state          <= in_flight ? ST_ACCUM : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
